// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and a one-entry response skid.
// One request in flight at a time; execute redirects squash any response still in flight.
module fetch_stage #(
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallD,
    input  logic                  FlushD,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD,
    output logic                  FetchBusyF
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013);
    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(32'd4);
    localparam logic [DATA_WIDTH-1:0] ZERO_WORD  = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

    function automatic logic [DATA_WIDTH-1:0] align_pc(input logic [DATA_WIDTH-1:0] target);
        return target & ALIGN_MASK;
    endfunction

    fetch_state_t          state_r;
    fetch_state_t          state_next_s;
    logic [DATA_WIDTH-1:0] pcf_r;
    logic [DATA_WIDTH-1:0] pcf_next_s;
    logic [DATA_WIDTH-1:0] pcf_plus4_s;
    logic [DATA_WIDTH-1:0] redirect_pc_s;
    logic                  req_s;
    logic                  accept_s;

    logic                  skid_full_r;
    logic [DATA_WIDTH-1:0] skid_instr_r;
    logic [DATA_WIDTH-1:0] skid_pc_r;
    logic [DATA_WIDTH-1:0] skid_pcplus4_r;

    logic [DATA_WIDTH-1:0] instrd_r;
    logic [DATA_WIDTH-1:0] pcd_r;
    logic [DATA_WIDTH-1:0] pcplus4d_r;
    logic                  validd_r;

    assign pcf_plus4_s   = pcf_r + PC_STEP;
    assign redirect_pc_s = align_pc(PCTargetE);
    assign req_s         = (state_r == IDLE) & ~skid_full_r & ~PCSrcE;
    // A response is only taken when it is live and not being squashed this cycle.
    assign accept_s      = (state_r == WAIT) & imem_rvalid & ~PCSrcE;

    assign imem_req   = req_s;
    assign imem_addr  = pcf_r;
    assign FetchBusyF = (state_r != IDLE) | skid_full_r;

    assign instrD   = instrd_r;
    assign PCD      = pcd_r;
    assign PCPlus4D = pcplus4d_r;
    assign ValidD   = validd_r;

    // Fetch FSM next-state and next-PC selection.
    always_comb begin
        state_next_s = state_r;
        pcf_next_s   = pcf_r;
        case (state_r)
            IDLE: begin
                if (PCSrcE) begin
                    pcf_next_s = redirect_pc_s;
                end else if (req_s) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next_s = IDLE;
                    if (PCSrcE) begin
                        pcf_next_s = redirect_pc_s;
                    end else begin
                        pcf_next_s = pcf_plus4_s;
                    end
                end else if (PCSrcE) begin
                    pcf_next_s   = redirect_pc_s;
                    state_next_s = KILL;
                end else begin
                    state_next_s = WAIT;
                end
            end
            KILL: begin
                if (imem_rvalid) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = KILL;
                end
                if (PCSrcE) begin
                    pcf_next_s = redirect_pc_s;
                end else begin
                    pcf_next_s = pcf_r;
                end
            end
            default: begin
                state_next_s = IDLE;
                pcf_next_s   = pcf_r;
            end
        endcase
    end

    // Fetch state and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            pcf_r   <= RESET_PC;
        end else begin
            state_r <= state_next_s;
            pcf_r   <= pcf_next_s;
        end
    end

    // Skid entry: parks an accepted response that decode cannot take this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_full_r    <= 1'b0;
            skid_instr_r   <= ZERO_WORD;
            skid_pc_r      <= ZERO_WORD;
            skid_pcplus4_r <= ZERO_WORD;
        end else if (PCSrcE) begin
            skid_full_r <= 1'b0;
        end else if (accept_s && (StallD || FlushD)) begin
            skid_full_r    <= 1'b1;
            skid_instr_r   <= imem_rdata;
            skid_pc_r      <= pcf_r;
            skid_pcplus4_r <= pcf_plus4_s;
        end else if (skid_full_r && !FlushD && !StallD) begin
            skid_full_r <= 1'b0;
        end else begin
            skid_full_r <= skid_full_r;
        end
    end

    // IF/ID pipeline register: squash, hold, skid drain, fresh response, else bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instrd_r   <= NOP_INSTR;
            pcd_r      <= ZERO_WORD;
            pcplus4d_r <= ZERO_WORD;
            validd_r   <= 1'b0;
        end else if (PCSrcE || FlushD) begin
            instrd_r   <= NOP_INSTR;
            pcd_r      <= ZERO_WORD;
            pcplus4d_r <= ZERO_WORD;
            validd_r   <= 1'b0;
        end else if (StallD) begin
            instrd_r   <= instrd_r;
            pcd_r      <= pcd_r;
            pcplus4d_r <= pcplus4d_r;
            validd_r   <= validd_r;
        end else if (skid_full_r) begin
            instrd_r   <= skid_instr_r;
            pcd_r      <= skid_pc_r;
            pcplus4d_r <= skid_pcplus4_r;
            validd_r   <= 1'b1;
        end else if (accept_s) begin
            instrd_r   <= imem_rdata;
            pcd_r      <= pcf_r;
            pcplus4d_r <= pcf_plus4_s;
            validd_r   <= 1'b1;
        end else begin
            instrd_r   <= NOP_INSTR;
            pcd_r      <= ZERO_WORD;
            pcplus4d_r <= ZERO_WORD;
            validd_r   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable memory model feeds the DUT,
// expected decode-stage instructions are queued at issue and checked as decode consumes them.
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instrD, PCD, PCPlus4D;
    logic        ValidD, FetchBusyF;

    logic        mem_rvalid_r;
    logic [31:0] mem_rdata_r;
    logic        pend_r;
    int          cnt_r;
    logic [31:0] paddr_r;
    int          lat;
    logic        man_mode, man_rvalid;
    logic [31:0] man_rdata;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instrD     (instrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .FetchBusyF (FetchBusyF)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 ^ {a[23:0], 8'h00};
    endfunction

    assign imem_rvalid = man_mode ? man_rvalid : mem_rvalid_r;
    assign imem_rdata  = man_mode ? man_rdata  : mem_rdata_r;

    // Memory model: answers each request after 'lat' cycles (lat=1 -> next cycle).
    always @(posedge clk) begin
        mem_rvalid_r <= 1'b0;
        if (rst || man_mode) begin
            pend_r <= 1'b0;
        end else if (imem_req) begin
            if (lat <= 1) begin
                mem_rvalid_r <= 1'b1;
                mem_rdata_r  <= mem_word(imem_addr);
            end else begin
                pend_r  <= 1'b1;
                cnt_r   <= lat - 1;
                paddr_r <= imem_addr;
            end
        end else if (pend_r) begin
            if (cnt_r == 1) begin
                mem_rvalid_r <= 1'b1;
                mem_rdata_r  <= mem_word(paddr_r);
                pend_r       <= 1'b0;
            end else begin
                cnt_r <= cnt_r - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_sample();
        exp_t e;
        if (ValidD === 1'b1 && StallD === 1'b0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL sb_unexpected: observed instr %h pc %h expected no instruction", instrD, PCD);
            end else begin
                e = sb.pop_front();
                chk("sb_instrD", instrD, e.instr);
                chk("sb_PCD", PCD, e.pc);
                chk("sb_PCPlus4D", PCPlus4D, e.pc4);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            sb_sample();
            if (imem_req === 1'b1) begin
                found = 1'b1;
                chk(tag, imem_addr, addr);
            end
            @(posedge clk);
            #1;
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s_timeout: observed no request expected addr %h", tag, addr);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc);
        exp_t e;
        e.instr = mem_word(pc);
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        return e;
    endfunction

    initial begin
        rst = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        lat = 1; man_mode = 1'b0; man_rvalid = 1'b0; man_rdata = 32'h0;
        repeat (2) tick();
        chk("rst_instrD", instrD, 32'h0000_0013);
        chk("rst_PCD", PCD, 32'h0);
        chk("rst_PCPlus4D", PCPlus4D, 32'h0);
        chk("rst_ValidD", 32'(ValidD), 32'd0);
        chk("rst_busy", 32'(FetchBusyF), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        rst = 1'b0;

        // Basic fetch: first instruction and the following request.
        wait_req("req0", 32'h0, 5);
        sb.push_back(mk(32'h0));
        wait_req("req4", 32'h4, 5);
        sb.push_back(mk(32'h4));

        // Stall while the response for 0x8 arrives: it must land in the skid.
        wait_req("req8", 32'h8, 5);
        sb.push_back(mk(32'h8));
        StallD = 1'b1;
        tick();
        chk("stall_busy", 32'(FetchBusyF), 32'd1);
        chk("stall_req", 32'(imem_req), 32'd0);
        chk("stall_validd", 32'(ValidD), 32'd0);
        tick();
        chk("stall_req2", 32'(imem_req), 32'd0);
        StallD = 1'b0;
        tick();
        wait_req("reqC", 32'hC, 3);
        sb.push_back(mk(32'hC));
        tick();

        // Hold a valid instruction, then redirect while 0x10 is outstanding.
        StallD = 1'b1;
        lat = 3;
        wait_req("req10", 32'h10, 3);
        chk("hold_instrD", instrD, mem_word(32'hC));
        chk("hold_PCD", PCD, 32'hC);
        chk("hold_ValidD", 32'(ValidD), 32'd1);
        StallD = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h103;
        tick();
        PCSrcE = 1'b0;
        chk("kill_busy", 32'(FetchBusyF), 32'd1);
        chk("kill_req", 32'(imem_req), 32'd0);
        chk("kill_validd", 32'(ValidD), 32'd0);
        chk("kill_addr", imem_addr, 32'h100);
        tick();
        chk("kill_req2", 32'(imem_req), 32'd0);
        tick();
        chk("kill_drop", 32'(ValidD), 32'd0);
        lat = 1;
        wait_req("req100", 32'h100, 3);
        sb.push_back(mk(32'h100));
        tick();

        // Redirect in the same cycle as the response (unaligned target).
        wait_req("req104", 32'h104, 3);
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFE;
        tick();
        PCSrcE = 1'b0;
        chk("same_validd", 32'(ValidD), 32'd0);
        chk("same_busy", 32'(FetchBusyF), 32'd0);
        wait_req("reqFFC", 32'hFFFF_FFFC, 3);
        sb.push_back(mk(32'hFFFF_FFFC));
        tick();

        // PC wrap, then a flushed response that goes through the skid.
        wait_req("req_wrap", 32'h0, 3);
        sb.push_back(mk(32'h0));
        FlushD = 1'b1;
        tick();
        FlushD = 1'b0;
        chk("flush_busy", 32'(FetchBusyF), 32'd1);
        chk("flush_validd", 32'(ValidD), 32'd0);
        chk("flush_req", 32'(imem_req), 32'd0);
        tick();
        lat = 3;
        wait_req("req4b", 32'h4, 3);

        // Reset while WAIT; a stale response right after release is ignored.
        man_mode = 1'b1;
        rst = 1'b1;
        #1;
        chk("arst_validd", 32'(ValidD), 32'd0);
        chk("arst_busy", 32'(FetchBusyF), 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        tick();
        rst = 1'b0;
        man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
        #1;
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
        tick();
        man_rvalid = 1'b0;
        chk("stale_validd", 32'(ValidD), 32'd0);
        chk("stale_busy", 32'(FetchBusyF), 32'd1);
        tick();
        chk("stale_validd2", 32'(ValidD), 32'd0);
        man_rvalid = 1'b1; man_rdata = mem_word(32'h0);
        sb.push_back(mk(32'h0));
        tick();
        man_rvalid = 1'b0;
        tick();
        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Holds the fetch PC and issues one-outstanding requests to a variable-latency instruction memory.
- Presents instrD/PCD/PCPlus4D to decode, with stall, flush and execute-stage redirect support.
- A 1-entry skid buffer catches a response that arrives while decode is stalled.

Parameters:
- DATA_WIDTH, 32, width of instruction, PC and memory data.
- RESET_PC, 32'h0000_0000, PCF value after reset.

Ports:
- clk  input  1  clock (all state updates on rising edge).
- rst  input  1  asynchronous active-high reset.
- StallD  input  1  hazard unit: hold IF/ID register.
- FlushD  input  1  hazard unit: load bubble into IF/ID register.
- PCSrcE  input  1  execute: taken branch/jump redirect.
- PCTargetE  input  DATA_WIDTH  execute: redirect target.
- imem_req  output  1  request strobe; memory always accepts when high.
- imem_addr  output  DATA_WIDTH  request address (= PCF).
- imem_rvalid  input  1  response valid, at least 1 cycle after request.
- imem_rdata  input  DATA_WIDTH  response instruction.
- instrD  output  DATA_WIDTH  instruction to decode.
- PCD  output  DATA_WIDTH  PC of instrD.
- PCPlus4D  output  DATA_WIDTH  PCD+4.
- ValidD  output  1  instrD is a real instruction (0 = bubble).
- FetchBusyF  output  1  high when state != IDLE or skid full.

Behaviour:
- Reset (async): PCF=RESET_PC; state=IDLE; skid empty; instrD=32'h0000_0013 (NOP); PCD=0; PCPlus4D=0; ValidD=0.
- States: IDLE (nothing outstanding), WAIT (live request outstanding), KILL (stale request outstanding).
- imem_req = (state==IDLE) & skid empty & !PCSrcE; imem_addr=PCF (combinational).
- IDLE: req issued -> WAIT. PCSrcE -> PCF<=target, stay IDLE. imem_rvalid in IDLE is ignored, which covers stale responses after reset.
- WAIT:
  - rvalid & !PCSrcE -> response accepted; PCF<=PCF+4; -> IDLE.
  - rvalid & PCSrcE -> response discarded; PCF<=target; -> IDLE.
  - !rvalid & PCSrcE -> PCF<=target; -> KILL.
- KILL: rvalid -> discard, -> IDLE. PCSrcE -> PCF<=target, stay KILL.
- Redirect target: PCF<={PCTargetE[DATA_WIDTH-1:2],2'b00}. PC+4 arithmetic is modulo 2^DATA_WIDTH (wraps).
- IF/ID update priority, per cycle:
  1. PCSrcE or FlushD -> bubble (instrD=NOP, ValidD=0, PCD/PCPlus4D=0).
  2. StallD -> hold all four outputs.
  3. Skid full -> load skid entry; skid empties.
  4. Accepted response -> load {imem_rdata, PCF, PCF+4, 1}.
  5. Otherwise -> bubble.
- Skid: an accepted response that is not loaded into IF/ID (StallD=1 or FlushD=1) is written to skid {rdata, PC, PC+4}.
- Skid cleared on PCSrcE, which has priority over the write.
- Skid full blocks new requests, so at most one outstanding request plus one skid entry exist. No response can arrive while skid is full.
- Throughput: at most one instruction per 2 cycles (issue, then response). Back-to-back issue is out of scope.
- Latency: zero-latency-equivalent memory (rvalid the cycle after req) gives instrD valid 2 edges after the issue cycle.

Test Plan:
- Reset, memory returns rdata=0x00500093 one cycle after each req -> first req addr 0x0; instrD=0x00500093, PCD=0, PCPlus4D=4, ValidD=1. Next req addr 0x4.
- StallD=1 when response for PC=0x8 arrives -> instrD/PCD hold; skid full; imem_req=0 while stalled. StallD=0 -> PCD=0x8, then req addr 0xC next cycle.
- PCSrcE=1, PCTargetE=0x103 while request for 0x10 is outstanding, rvalid 3 cycles later -> state KILL, response dropped, ValidD=0. Next req addr 0x100.
- PCSrcE and rvalid in the same cycle -> response discarded, bubble in D, next req addr=target.
- PCF=0xFFFF_FFFC accepted -> PCPlus4D=0x0000_0000, next req addr 0x0.
- rst pulsed while in WAIT, rvalid arrives the cycle after release -> ignored; req issued at RESET_PC; ValidD stays 0 until the new response.
